// File: rtl/blink_sequencer.sv
// blink_sequencer: queues {count, on_ms, off_ms} blink commands and plays them
// back in order on one LED, timed by a clk-to-ms prescaler.
module blink_sequencer #(
  parameter int unsigned CLK_PER_MS = 100000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [7:0]                   cmd_count,
  input  logic [15:0]                  cmd_on_ms,
  input  logic [15:0]                  cmd_off_ms,
  input  logic                         abort,
  output logic                         led,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(FIFO_DEPTH):0]  q_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

  typedef struct packed {
    logic [7:0]  count;
    logic [15:0] on_ms;
    logic [15:0] off_ms;
  } cmd_t;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ON, S_OFF, S_DONE} state_t;

  cmd_t          r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_rem;
  logic [15:0]   r_on;
  logic [15:0]   r_off;
  logic [PW-1:0] r_pre;
  logic [15:0]   r_ms;
  logic          r_led;
  logic          r_busy;
  logic          r_done;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_tick;
  logic          w_phase_end;
  logic          w_led_nxt;
  logic          w_busy_nxt;
  logic          w_done_nxt;
  logic [15:0]   w_target;
  logic [LW-1:0] w_level_nxt;
  cmd_t          w_head;

  assign w_full      = (r_level == LW'(FIFO_DEPTH));
  assign cmd_ready   = !w_full && !abort;
  assign w_push      = cmd_valid && cmd_ready;
  assign w_pop       = (r_state == S_LOAD);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_tick      = (r_pre == PW'(CLK_PER_MS - 1));
  assign w_target    = (r_state == S_ON) ? r_on : r_off;
  // Phase lasts exactly target ms; counters start from zero on every entry.
  assign w_phase_end = w_tick && (r_ms == w_target - 16'd1);

  assign led     = r_led;
  assign busy    = r_busy;
  assign done    = r_done;
  assign q_level = r_level;

  always_comb begin
    w_level_nxt = r_level;
    if (abort)
      w_level_nxt = '0;
    else if (w_push && !w_pop)
      w_level_nxt = r_level + LW'(1);
    else if (!w_push && w_pop)
      w_level_nxt = r_level - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= {cmd_count, cmd_on_ms, cmd_off_ms};
  end

  // Queue pointers, active-command registers and ms timing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_rem    <= '0;
      r_on     <= '0;
      r_off    <= '0;
      r_pre    <= '0;
      r_ms     <= '0;
    end else if (abort) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_rem    <= '0;
      r_on     <= '0;
      r_off    <= '0;
      r_pre    <= '0;
      r_ms     <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= w_level_nxt;
      if (r_state == S_LOAD) begin
        r_rem <= w_head.count;
        r_on  <= (w_head.on_ms == 16'd0) ? 16'd1 : w_head.on_ms;
        r_off <= w_head.off_ms;
      end else if (w_phase_end && ((r_state == S_OFF) ||
                                   ((r_state == S_ON) && (r_off == 16'd0)))) begin
        r_rem <= r_rem - 8'd1;
      end
      if (((r_state != S_ON) && (r_state != S_OFF)) || w_phase_end) begin
        r_pre <= '0;
        r_ms  <= '0;
      end else if (w_tick) begin
        r_pre <= '0;
        r_ms  <= r_ms + 16'd1;
      end else begin
        r_pre <= r_pre + PW'(1);
      end
    end
  end

  // State register plus registered output decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_led   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_led   <= w_led_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (r_level != '0) w_state_nxt = S_LOAD;
        S_LOAD: w_state_nxt = (w_head.count == 8'd0) ? S_DONE : S_ON;
        S_ON: begin
          if (w_phase_end) begin
            if (r_off != 16'd0)    w_state_nxt = S_OFF;
            else if (r_rem > 8'd1) w_state_nxt = S_ON;
            else                   w_state_nxt = S_DONE;
          end
        end
        S_OFF: begin
          if (w_phase_end)
            w_state_nxt = (r_rem > 8'd1) ? S_ON : S_DONE;
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_led_nxt  = 1'b0;
    w_done_nxt = 1'b0;
    w_busy_nxt = 1'b0;
    if (w_state_nxt == S_ON)
      w_led_nxt = 1'b1;
    if (w_state_nxt == S_DONE)
      w_done_nxt = 1'b1;
    if ((w_state_nxt != S_IDLE) || (w_level_nxt != '0))
      w_busy_nxt = 1'b1;
  end

endmodule
